// File: rtl/cbs_pkg.sv
// Shared types and arithmetic for credit-based shaping blocks.
package cbs_pkg;

   localparam int CBS_CREDIT_WIDTH = 32;
   localparam int CBS_MAX_W        = 64;

   typedef enum logic {
      IDLE = 1'b0,
      XMIT = 1'b1
   } cbs_state_e;

   typedef enum logic [1:0] {
      UPD_HOLD = 2'd0,
      UPD_SEND = 2'd1,
      UPD_GAIN = 2'd2,
      UPD_ZERO = 2'd3
   } cbs_upd_e;

   // Adds or subtracts an unsigned slope from a signed credit and clamps to
   // [lo, hi]. Two guard bits mean the intermediate sum can never wrap.
   function automatic logic signed [CBS_MAX_W-1:0] cbs_sat_step(
      input logic signed [CBS_MAX_W-1:0] cur,
      input logic        [CBS_MAX_W-1:0] slope,
      input logic                        sub,
      input logic signed [CBS_MAX_W-1:0] lo,
      input logic signed [CBS_MAX_W-1:0] hi
   );
      logic signed [CBS_MAX_W+1:0] acc;
      logic signed [CBS_MAX_W+1:0] step;
      logic signed [CBS_MAX_W+1:0] lo_w;
      logic signed [CBS_MAX_W+1:0] hi_w;
      step = $signed({2'b00, slope});
      acc  = $signed({{2{cur[CBS_MAX_W-1]}}, cur}) + (sub ? -step : step);
      lo_w = $signed({{2{lo[CBS_MAX_W-1]}}, lo});
      hi_w = $signed({{2{hi[CBS_MAX_W-1]}}, hi});
      if (acc > hi_w) begin
         acc = hi_w;
      end else if (acc < lo_w) begin
         acc = lo_w;
      end
      return acc[CBS_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/cbs_credit_calc.sv
// Signed credit register: spend on transfer, earn while waiting, drop to zero
// when the queue empties with surplus, always clamped to [lo_credit, hi_credit].
module cbs_credit_calc
   import cbs_pkg::*;
#(
   parameter int CREDIT_WIDTH = CBS_CREDIT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    xfer,
   input  logic                    s_valid,
   input  logic [CREDIT_WIDTH-1:0] idle_slope,
   input  logic [CREDIT_WIDTH-1:0] send_slope,
   input  logic [CREDIT_WIDTH-1:0] hi_credit,
   input  logic [CREDIT_WIDTH-1:0] lo_credit,
   output logic [CREDIT_WIDTH-1:0] credit
);

   localparam int EXT = CBS_MAX_W - CREDIT_WIDTH;

   logic [CREDIT_WIDTH-1:0]        credit_q;
   logic [CREDIT_WIDTH-1:0]        credit_d;
   cbs_upd_e                       upd;
   logic signed [CBS_MAX_W-1:0]    cur_x;
   logic signed [CBS_MAX_W-1:0]    lo_x;
   logic signed [CBS_MAX_W-1:0]    hi_x;
   logic        [CBS_MAX_W-1:0]    idle_x;
   logic        [CBS_MAX_W-1:0]    send_x;
   logic signed [CBS_MAX_W-1:0]    res_x;
   logic        [EXT-1:0]          res_unused;

   always_comb begin
      cur_x  = $signed({{EXT{credit_q[CREDIT_WIDTH-1]}}, credit_q});
      lo_x   = $signed({{EXT{lo_credit[CREDIT_WIDTH-1]}}, lo_credit});
      hi_x   = $signed({{EXT{hi_credit[CREDIT_WIDTH-1]}}, hi_credit});
      idle_x = {{EXT{1'b0}}, idle_slope};
      send_x = {{EXT{1'b0}}, send_slope};

      upd = UPD_HOLD;
      if (xfer) begin
         upd = UPD_SEND;
      end else if (s_valid || credit_q[CREDIT_WIDTH-1]) begin
         upd = UPD_GAIN;
      end else if (credit_q != '0) begin
         upd = UPD_ZERO;
      end

      // Zeroing goes through the same clamp so a misconfigured range still holds.
      unique case (upd)
         UPD_SEND: res_x = cbs_sat_step(cur_x, send_x, 1'b1, lo_x, hi_x);
         UPD_GAIN: res_x = cbs_sat_step(cur_x, idle_x, 1'b0, lo_x, hi_x);
         UPD_ZERO: res_x = cbs_sat_step('0, '0, 1'b0, lo_x, hi_x);
         default:  res_x = cur_x;
      endcase

      credit_d   = res_x[CREDIT_WIDTH-1:0];
      res_unused = res_x[CBS_MAX_W-1:CREDIT_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q <= '0;
      end else begin
         credit_q <= credit_d;
      end
   end

   assign credit = credit_q;

endmodule

// File: rtl/cbs_gate.sv
// Credit-based shaper gate: holds a frame at its head until credit >= 0, then
// passes the whole frame with zero latency. CBS_GATE_STATS_EN adds counters.
module cbs_gate
   import cbs_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
   parameter int CREDIT_WIDTH = CBS_CREDIT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CREDIT_WIDTH-1:0] idle_slope,
   input  logic [CREDIT_WIDTH-1:0] send_slope,
   input  logic [CREDIT_WIDTH-1:0] hi_credit,
   input  logic [CREDIT_WIDTH-1:0] lo_credit,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
`ifdef CBS_GATE_STATS_EN
   output logic [31:0]             frame_count,
   output logic [31:0]             blocked_cycles,
`endif
   output logic [CREDIT_WIDTH-1:0] credit
);

   cbs_state_e state_q;
   cbs_state_e state_d;
   logic       gate_open;
   logic       xfer;

   cbs_credit_calc #(
      .CREDIT_WIDTH(CREDIT_WIDTH)
   ) u_credit (
      .clk       (clk),
      .rst       (rst),
      .xfer      (xfer),
      .s_valid   (s_axis_tvalid),
      .idle_slope(idle_slope),
      .send_slope(send_slope),
      .hi_credit (hi_credit),
      .lo_credit (lo_credit),
      .credit    (credit)
   );

   // Once a frame has started it is never cut, whatever the credit does.
   always_comb begin
      gate_open     = (state_q == XMIT) || !credit[CREDIT_WIDTH-1];
      m_axis_tvalid = s_axis_tvalid && gate_open && !rst;
      s_axis_tready = m_axis_tready && gate_open && !rst;
      xfer          = m_axis_tvalid && m_axis_tready;
      m_axis_tdata  = s_axis_tdata;
      m_axis_tkeep  = s_axis_tkeep;
      m_axis_tlast  = s_axis_tlast;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (xfer && !s_axis_tlast) state_d = XMIT;
         XMIT:    if (xfer && s_axis_tlast)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef CBS_GATE_STATS_EN
   logic [31:0] frame_count_q;
   logic [31:0] frame_count_d;
   logic [31:0] blocked_cycles_q;
   logic [31:0] blocked_cycles_d;

   always_comb begin
      frame_count_d    = frame_count_q;
      blocked_cycles_d = blocked_cycles_q;
      if (xfer && s_axis_tlast) frame_count_d = frame_count_q + 32'd1;
      if (s_axis_tvalid && !gate_open) blocked_cycles_d = blocked_cycles_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count_q    <= '0;
         blocked_cycles_q <= '0;
      end else begin
         frame_count_q    <= frame_count_d;
         blocked_cycles_q <= blocked_cycles_d;
      end
   end

   assign frame_count    = frame_count_q;
   assign blocked_cycles = blocked_cycles_q;
`endif

endmodule

// File: tb/tb_cbs_gate.sv
// Bench for cbs_gate: vector table, directed corner sequences and random
// traffic checked against a cycle model of the shaper rules.
module tb_cbs_gate;

   localparam int DW = 8;
   localparam int KW = 1;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] idle, send, hi, lo;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          vld, last, rdy;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid, m_axis_tlast;
   logic [CW-1:0] credit;
`ifdef CBS_GATE_STATS_EN
   logic [31:0]   frame_count, blocked_cycles;
`endif

   always #5 clk = ~clk;

   cbs_gate #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CREDIT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .idle_slope(idle), .send_slope(send), .hi_credit(hi), .lo_credit(lo),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(vld), .s_axis_tready(s_axis_tready), .s_axis_tlast(last),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(rdy), .m_axis_tlast(m_axis_tlast),
`ifdef CBS_GATE_STATS_EN
      .frame_count(frame_count), .blocked_cycles(blocked_cycles),
`endif
      .credit(credit)
   );

   int     total = 0;
   int     bad   = 0;
   longint mcred = 0;
   bit     minf  = 0;
   longint mframes = 0, mblocked = 0;
   logic   obs_mv, obs_sr;
   longint obs_cred;

   typedef struct {
      logic        r, v, l, rd;
      int unsigned idle, send;
      logic        emv, esr;
      longint      ecr;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint clampv(input longint v);
      longint h, l;
      h = longint'($signed(hi));
      l = longint'($signed(lo));
      if (v > h) return h;
      if (v < l) return l;
      return v;
   endfunction

   function automatic longint cred_now();
      return longint'($signed(credit));
   endfunction

   task automatic drive(input logic r, input logic v, input logic l, input logic rd);
      rst = r; vld = v; last = l; rdy = rd;
      s_axis_tdata = DW'($urandom);
      s_axis_tkeep = KW'($urandom);
   endtask

   // Checks combinational outputs against the model, then advances one clock.
   task automatic cyc();
      bit op, emv, esr, xf;
      #1;
      op  = minf || (mcred >= 0);
      emv = vld && op && !rst;
      esr = rdy && op && !rst;
      obs_mv = m_axis_tvalid; obs_sr = s_axis_tready; obs_cred = cred_now();
      chk("m_tvalid", longint'(m_axis_tvalid), longint'(emv));
      chk("s_tready", longint'(s_axis_tready), longint'(esr));
      chk("credit", obs_cred, mcred);
      if (emv) begin
         chk("tdata", longint'(m_axis_tdata), longint'(s_axis_tdata));
         chk("tkeep", longint'(m_axis_tkeep), longint'(s_axis_tkeep));
         chk("tlast", longint'(m_axis_tlast), longint'(last));
      end
      xf = emv && rdy;
      @(posedge clk);
      if (rst) begin
         mcred = 0; minf = 0; mframes = 0; mblocked = 0;
      end else begin
         if (vld && !op) mblocked++;
         if (xf) begin
            mcred = clampv(mcred - longint'(send));
            minf  = !last;
            if (last) mframes++;
         end else if (vld || mcred < 0) begin
            mcred = clampv(mcred + longint'(idle));
         end else if (mcred > 0) begin
            mcred = clampv(0);
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0);
      cyc();
   endtask

   initial begin
      longint sat_exp[4];
      longint c0;
      int     closed;
      bit     found;
      sat_exp = '{100, 200, 250, 250};

      idle = 4; send = 3; hi = 250; lo = -32'sd1000;
      drive(1, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);

      // r v l rd idle send emv esr credit-after
      tbl[0]  = '{1, 1, 0, 1,   4,    3, 0, 0,     0};
      tbl[1]  = '{0, 1, 0, 1,   4,    3, 1, 1,    -3};
      tbl[2]  = '{0, 1, 0, 0,   4,    3, 1, 0,     1};
      tbl[3]  = '{0, 1, 1, 1,   4,    3, 1, 1,    -2};
      tbl[4]  = '{0, 1, 1, 1,   4,    3, 0, 0,     2};
      tbl[5]  = '{0, 0, 0, 1,   4,    3, 0, 1,     0};
      tbl[6]  = '{0, 0, 0, 1,   4,    3, 0, 1,     0};
      tbl[7]  = '{0, 1, 1, 1,   4, 2000, 1, 1, -1000};
      tbl[8]  = '{0, 0, 0, 0, 600,    3, 0, 0,  -400};
      tbl[9]  = '{0, 0, 0, 1, 600,    3, 0, 0,   200};
      tbl[10] = '{0, 1, 0, 0, 100,    3, 1, 0,   250};
      tbl[11] = '{0, 0, 0, 0, 100,    3, 0, 0,     0};
      for (int i = 0; i < 12; i++) begin
         idle = tbl[i].idle; send = tbl[i].send;
         drive(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].rd);
         cyc();
         chk($sformatf("vec%0d_mv", i), longint'(obs_mv), longint'(tbl[i].emv));
         chk($sformatf("vec%0d_sr", i), longint'(obs_sr), longint'(tbl[i].esr));
         chk($sformatf("vec%0d_credit", i), cred_now(), tbl[i].ecr);
      end

      // 64-beat frame from zero credit, then a follow-on frame waits it out.
      hi = 1000; lo = -32'sd1000; idle = 4; send = 3;
      do_reset();
      for (int i = 0; i < 64; i++) begin
         drive(0, 1, (i == 63), 1);
         cyc();
         chk("frame64_beat", longint'(obs_mv), 1);
      end
      chk("frame64_credit", cred_now(), -192);
      closed = 0; found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         drive(0, 1, 0, 1);
         cyc();
         if (obs_mv) begin
            found = 1;
            chk("first_beat_credit", obs_cred, 0);
         end else begin
            closed++;
         end
      end
      chk("first_beat_seen", longint'(found), 1);
      chk("closed_cycles", closed, 48);

      // Arbiter stall mid-frame: frame held open, credit keeps earning.
      c0 = cred_now();
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 0, 0);
         cyc();
         chk("stall_hold_mv", longint'(obs_mv), 1);
      end
      chk("stall_rise", cred_now() - c0, 40);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, (i == 2), 1);
         cyc();
         chk("resume_beat", longint'(obs_mv), 1);
      end

      // Saturation at hi_credit, then reset-on-empty.
      do_reset();
      hi = 250; idle = 100;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 0);
         cyc();
         chk($sformatf("sat%0d", i), cred_now(), sat_exp[i]);
      end
      drive(0, 0, 0, 0);
      cyc();
      chk("empty_reset", cred_now(), 0);

      // Reset at beat 20 of a 64-beat frame.
      hi = 1000; idle = 4; send = 3;
      do_reset();
      for (int i = 0; i < 19; i++) begin
         drive(0, 1, 0, 1);
         cyc();
      end
      drive(1, 1, 0, 1);
      cyc();
      chk("rst_mid_mv", longint'(obs_mv), 0);
      chk("rst_mid_credit", cred_now(), 0);
      drive(0, 1, 0, 1);
      cyc();
      chk("restart_mv", longint'(obs_mv), 1);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, (i == 3), 1);
         cyc();
      end

      // Random traffic with periodic reconfiguration, including extreme ranges.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (n % 150 == 0) begin
            if ($urandom_range(0, 4) == 0) begin
               hi = 32'h7FFF_FFFF; lo = 32'h8000_0000;
               send = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
               idle = 32'h7000_0000 + 32'($urandom_range(0, 255));
            end else begin
               hi   = 32'($urandom_range(0, 3000));
               lo   = -32'($urandom_range(0, 3000));
               idle = 32'($urandom_range(0, 200));
               send = 32'($urandom_range(0, 600));
            end
         end
         drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 7));
         cyc();
      end

`ifdef CBS_GATE_STATS_EN
      #1;
      chk("frame_count", longint'(frame_count), mframes & 64'hFFFF_FFFF);
      chk("blocked_cycles", longint'(blocked_cycles), mblocked & 64'hFFFF_FFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
